// File: rtl/color_centroid.sv
// color_centroid
// Builds a 1-bit mask from a Cr window on the pixel stream. It also keeps
// per-frame sums of the masked pixel coordinates and their count. At every
// frame boundary the mask centroid (x, y) and area are produced by two
// restoring dividers that run side by side.
module color_centroid #(
   parameter int H_WIDTH   = 11,
   parameter int V_WIDTH   = 10,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 20
) (
   input  logic                 clk_pixel,
   input  logic                 sys_rst_pixel_n,
   input  logic [H_WIDTH-1:0]   hcount_in,
   input  logic [V_WIDTH-1:0]   vcount_in,
   input  logic                 data_valid_in,
   input  logic                 new_frame_in,
   input  logic [7:0]           y_in,
   input  logic [7:0]           cr_in,
   input  logic [7:0]           cb_in,
   input  logic [7:0]           lower_cr_in,
   input  logic [7:0]           upper_cr_in,
   output logic                 mask_out,
   output logic [H_WIDTH-1:0]   x_out,
   output logic [V_WIDTH-1:0]   y_out,
   output logic [CNT_WIDTH-1:0] area_out,
   output logic                 centroid_valid_out,
   output logic                 busy_out
);

   localparam int ITER_WIDTH = $clog2(ACC_WIDTH);
   localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(ACC_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE_ACC,
      DIVIDE,
      REPORT
   } state_t;

   state_t state;

   // Threshold result for the pixel currently on the inputs
   logic hit;

   // Running per-frame accumulators
   logic [CNT_WIDTH-1:0] cnt;
   logic [ACC_WIDTH-1:0] sum_x;
   logic [ACC_WIDTH-1:0] sum_y;
   logic [ACC_WIDTH-1:0] hcount_ext;
   logic [ACC_WIDTH-1:0] vcount_ext;

   // Divider operands and working registers
   logic [CNT_WIDTH-1:0]  div_cnt;
   logic [ACC_WIDTH-1:0]  quo_x;
   logic [ACC_WIDTH-1:0]  quo_y;
   logic [ACC_WIDTH-1:0]  rem_x;
   logic [ACC_WIDTH-1:0]  rem_y;
   logic [ITER_WIDTH-1:0] iter;

   // One restoring step for each divider
   logic [ACC_WIDTH:0]   divisor_ext;
   logic [ACC_WIDTH:0]   shift_x;
   logic [ACC_WIDTH:0]   shift_y;
   logic                 ge_x;
   logic                 ge_y;
   logic [ACC_WIDTH-1:0] rem_x_next;
   logic [ACC_WIDTH-1:0] rem_y_next;
   logic [ACC_WIDTH-1:0] quo_x_next;
   logic [ACC_WIDTH-1:0] quo_y_next;

   // Luma and Cb pass through this block but are not used for segmentation
   logic unused_pixel_bits;
   assign unused_pixel_bits = ^{y_in, cb_in};

   // Inclusive unsigned window. An inverted window (upper < lower) can never match.
   assign hit = data_valid_in
                && (cr_in >= lower_cr_in)
                && (cr_in <= upper_cr_in);

   assign hcount_ext = {{(ACC_WIDTH-H_WIDTH){1'b0}}, hcount_in};
   assign vcount_ext = {{(ACC_WIDTH-V_WIDTH){1'b0}}, vcount_in};

   // The remainder always stays below the divisor, so it fits in ACC_WIDTH bits
   // after each step. The shifted value needs one extra bit for the compare.
   assign divisor_ext = {{(ACC_WIDTH+1-CNT_WIDTH){1'b0}}, div_cnt};
   assign shift_x     = {rem_x, quo_x[ACC_WIDTH-1]};
   assign shift_y     = {rem_y, quo_y[ACC_WIDTH-1]};
   assign ge_x        = (shift_x >= divisor_ext);
   assign ge_y        = (shift_y >= divisor_ext);
   assign rem_x_next  = ge_x ? ACC_WIDTH'(shift_x - divisor_ext) : ACC_WIDTH'(shift_x);
   assign rem_y_next  = ge_y ? ACC_WIDTH'(shift_y - divisor_ext) : ACC_WIDTH'(shift_y);
   assign quo_x_next  = {quo_x[ACC_WIDTH-2:0], ge_x};
   assign quo_y_next  = {quo_y[ACC_WIDTH-2:0], ge_y};

   // Register the mask so it lines up one cycle behind the pixel
   always_ff @(posedge clk_pixel or negedge sys_rst_pixel_n) begin
      if (!sys_rst_pixel_n) begin
         mask_out <= 1'b0;
      end else begin
         mask_out <= hit;
      end
   end

   // Accumulate masked pixels. At a frame boundary the count and sums restart
   // from the boundary pixel itself, because that pixel belongs to the new frame.
   always_ff @(posedge clk_pixel or negedge sys_rst_pixel_n) begin
      if (!sys_rst_pixel_n) begin
         cnt   <= '0;
         sum_x <= '0;
         sum_y <= '0;
      end else if (new_frame_in) begin
         cnt   <= hit ? CNT_WIDTH'(1) : '0;
         sum_x <= hit ? hcount_ext : '0;
         sum_y <= hit ? vcount_ext : '0;
      end else if (hit) begin
         cnt   <= cnt + CNT_WIDTH'(1);
         sum_x <= sum_x + hcount_ext;
         sum_y <= sum_y + vcount_ext;
      end
   end

   // Frame-boundary sequencer. It snapshots the sums, runs both dividers MSB
   // first for ACC_WIDTH cycles, then registers the centroid and pulses valid.
   always_ff @(posedge clk_pixel or negedge sys_rst_pixel_n) begin
      if (!sys_rst_pixel_n) begin
         state              <= IDLE_ACC;
         div_cnt            <= '0;
         quo_x              <= '0;
         quo_y              <= '0;
         rem_x              <= '0;
         rem_y              <= '0;
         iter               <= '0;
         x_out              <= '0;
         y_out              <= '0;
         area_out           <= '0;
         centroid_valid_out <= 1'b0;
         busy_out           <= 1'b0;
      end else begin
         case (state)
            IDLE_ACC: begin
               centroid_valid_out <= 1'b0;
               if (new_frame_in) begin
                  if (cnt != '0) begin
                     div_cnt  <= cnt;
                     quo_x    <= sum_x;
                     quo_y    <= sum_y;
                     rem_x    <= '0;
                     rem_y    <= '0;
                     iter     <= '0;
                     busy_out <= 1'b1;
                     state    <= DIVIDE;
                  end else begin
                     area_out           <= '0;
                     centroid_valid_out <= 1'b1;
                     state              <= REPORT;
                  end
               end
            end

            DIVIDE: begin
               quo_x <= quo_x_next;
               quo_y <= quo_y_next;
               rem_x <= rem_x_next;
               rem_y <= rem_y_next;
               iter  <= iter + ITER_WIDTH'(1);
               if (iter == LAST_ITER) begin
                  x_out              <= quo_x_next[H_WIDTH-1:0];
                  y_out              <= quo_y_next[V_WIDTH-1:0];
                  area_out           <= div_cnt;
                  centroid_valid_out <= 1'b1;
                  busy_out           <= 1'b0;
                  state              <= REPORT;
               end
            end

            REPORT: begin
               centroid_valid_out <= 1'b0;
               state              <= IDLE_ACC;
            end

            default: begin
               centroid_valid_out <= 1'b0;
               busy_out           <= 1'b0;
               state              <= IDLE_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_centroid.sv
// tb_color_centroid
// Self-checking bench for color_centroid. It runs a mask vector table and
// hand-written frame sequences, then random frames. All of these are compared
// every cycle against a frame-level reference model (sums, counts, division).
module tb_color_centroid;

   localparam int H_WIDTH   = 11;
   localparam int V_WIDTH   = 10;
   localparam int ACC_WIDTH = 32;
   localparam int CNT_WIDTH = 20;
   localparam int DIV_LAT   = ACC_WIDTH;

   logic                 clk_pixel;
   logic                 sys_rst_pixel_n;
   logic [H_WIDTH-1:0]   hcount_in;
   logic [V_WIDTH-1:0]   vcount_in;
   logic                 data_valid_in;
   logic                 new_frame_in;
   logic [7:0]           y_in;
   logic [7:0]           cr_in;
   logic [7:0]           cb_in;
   logic [7:0]           lower_cr_in;
   logic [7:0]           upper_cr_in;
   logic                 mask_out;
   logic [H_WIDTH-1:0]   x_out;
   logic [V_WIDTH-1:0]   y_out;
   logic [CNT_WIDTH-1:0] area_out;
   logic                 centroid_valid_out;
   logic                 busy_out;

   color_centroid #(
      .H_WIDTH  (H_WIDTH),
      .V_WIDTH  (V_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk_pixel         (clk_pixel),
      .sys_rst_pixel_n   (sys_rst_pixel_n),
      .hcount_in         (hcount_in),
      .vcount_in         (vcount_in),
      .data_valid_in     (data_valid_in),
      .new_frame_in      (new_frame_in),
      .y_in              (y_in),
      .cr_in             (cr_in),
      .cb_in             (cb_in),
      .lower_cr_in       (lower_cr_in),
      .upper_cr_in       (upper_cr_in),
      .mask_out          (mask_out),
      .x_out             (x_out),
      .y_out             (y_out),
      .area_out          (area_out),
      .centroid_valid_out(centroid_valid_out),
      .busy_out          (busy_out)
   );

   // Free-running pixel clock
   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   typedef struct {
      logic valid;
      int   cr;
      int   lo;
      int   up;
      logic exp_mask;
   } mask_vec_t;

   mask_vec_t mask_table[14];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int win_lo = 100;
   int win_up = 200;

   // Reference model state
   longint m_sum_x;
   longint m_sum_y;
   int     m_cnt;
   logic   m_pending;
   int     m_due;
   int     m_next_x, m_next_y, m_next_area;
   int     m_shown_x, m_shown_y, m_shown_area;
   int     pulse_count;
   int     last_pulse_cyc;

   int nf_cyc;
   int p0;
   int len;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic model_reset();
      m_sum_x      = 0;
      m_sum_y      = 0;
      m_cnt        = 0;
      m_pending    = 1'b0;
      m_due        = 0;
      m_next_x     = 0;
      m_next_y     = 0;
      m_next_area  = 0;
      m_shown_x    = 0;
      m_shown_y    = 0;
      m_shown_area = 0;
   endtask

   task automatic monitor_outputs(input logic exp_mask);
      logic exp_valid;
      logic exp_busy;
      exp_valid = m_pending && (cyc == m_due);
      exp_busy  = m_pending && (cyc < m_due);
      if (exp_valid) begin
         m_shown_x    = m_next_x;
         m_shown_y    = m_next_y;
         m_shown_area = m_next_area;
      end
      if (centroid_valid_out === 1'b1) begin
         pulse_count++;
         last_pulse_cyc = cyc;
      end
      check_output("mask_out", mask_out, exp_mask);
      check_output("centroid_valid_out", centroid_valid_out, exp_valid);
      check_output("busy_out", busy_out, exp_busy);
      check_output("x_out", x_out, m_shown_x);
      check_output("y_out", y_out, m_shown_y);
      check_output("area_out", area_out, m_shown_area);
   endtask

   task automatic apply_stimulus(input logic valid, input int h, input int v, input int cr, input logic nf);
      logic hit;
      hit = valid && (cr >= win_lo) && (cr <= win_up);
      data_valid_in = valid;
      hcount_in     = H_WIDTH'(h);
      vcount_in     = V_WIDTH'(v);
      cr_in         = 8'(cr);
      y_in          = 8'($urandom);
      cb_in         = 8'($urandom);
      lower_cr_in   = 8'(win_lo);
      upper_cr_in   = 8'(win_up);
      new_frame_in  = nf;
      cyc++;
      if (nf) begin
         if (!m_pending || cyc > m_due + 1) begin
            m_pending = 1'b1;
            if (m_cnt == 0) begin
               m_next_x    = m_shown_x;
               m_next_y    = m_shown_y;
               m_next_area = 0;
               m_due       = cyc;
            end else begin
               m_next_x    = int'((m_sum_x / longint'(m_cnt)) % (longint'(1) << H_WIDTH));
               m_next_y    = int'((m_sum_y / longint'(m_cnt)) % (longint'(1) << V_WIDTH));
               m_next_area = m_cnt;
               m_due       = cyc + DIV_LAT;
            end
         end
         m_cnt   = hit ? 1 : 0;
         m_sum_x = hit ? longint'(h) : 0;
         m_sum_y = hit ? longint'(v) : 0;
      end else if (hit) begin
         m_cnt++;
         m_sum_x += h;
         m_sum_y += v;
      end
      @(posedge clk_pixel);
      #1;
      monitor_outputs(hit);
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic do_reset(input int hold_cycles);
      sys_rst_pixel_n = 1'b0;
      data_valid_in   = 1'b0;
      new_frame_in    = 1'b0;
      hcount_in       = '0;
      vcount_in       = '0;
      y_in            = '0;
      cr_in           = '0;
      cb_in           = '0;
      lower_cr_in     = 8'(win_lo);
      upper_cr_in     = 8'(win_up);
      model_reset();
      repeat (hold_cycles) @(posedge clk_pixel);
      #1;
      sys_rst_pixel_n = 1'b1;
   endtask

   // Watchdog so a stuck run still ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      mask_table[0]  = '{1'b1, 120, 120, 130, 1'b1};
      mask_table[1]  = '{1'b1, 130, 120, 130, 1'b1};
      mask_table[2]  = '{1'b1, 119, 120, 130, 1'b0};
      mask_table[3]  = '{1'b1, 131, 120, 130, 1'b0};
      mask_table[4]  = '{1'b1, 125, 120, 130, 1'b1};
      mask_table[5]  = '{1'b0, 125, 120, 130, 1'b0};
      mask_table[6]  = '{1'b1, 150, 200, 100, 1'b0};
      mask_table[7]  = '{1'b1, 100, 200, 100, 1'b0};
      mask_table[8]  = '{1'b1, 200, 200, 100, 1'b0};
      mask_table[9]  = '{1'b1,   0,   0, 255, 1'b1};
      mask_table[10] = '{1'b1, 255,   0, 255, 1'b1};
      mask_table[11] = '{1'b1,  77,  77,  77, 1'b1};
      mask_table[12] = '{1'b1,  78,  77,  77, 1'b0};
      mask_table[13] = '{1'b1,  76,  77,  77, 1'b0};

      pulse_count    = 0;
      last_pulse_cyc = -1;

      do_reset(3);
      check_output("reset_mask", mask_out, 0);
      check_output("reset_x", x_out, 0);
      check_output("reset_y", y_out, 0);
      check_output("reset_area", area_out, 0);
      check_output("reset_valid", centroid_valid_out, 0);
      check_output("reset_busy", busy_out, 0);

      // Single hit at (640,360)
      win_lo = 100;
      win_up = 200;
      idle(3);
      apply_stimulus(1'b1, 640, 360, 150, 1'b0);
      apply_stimulus(1'b1, 10, 10, 50, 1'b0);
      apply_stimulus(1'b1, 11, 10, 250, 1'b0);
      p0 = pulse_count;
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      nf_cyc = cyc;
      idle(40);
      check_output("single_latency", last_pulse_cyc - nf_cyc, 32);
      check_output("single_pulses", pulse_count - p0, 1);
      check_output("single_x", x_out, 640);
      check_output("single_y", y_out, 360);
      check_output("single_area", area_out, 1);

      // Rectangle x 100..109, y 200..204 plus out-of-window filler
      for (int yy = 200; yy <= 204; yy++) begin
         for (int xx = 100; xx <= 109; xx++) apply_stimulus(1'b1, xx, yy, 150, 1'b0);
         apply_stimulus(1'b1, 300, yy, 90, 1'b0);
      end
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      nf_cyc = cyc;
      idle(40);
      check_output("rect_latency", last_pulse_cyc - nf_cyc, 32);
      check_output("rect_x", x_out, 104);
      check_output("rect_y", y_out, 202);
      check_output("rect_area", area_out, 50);

      // Empty frame keeps the previous centroid
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      nf_cyc = cyc;
      check_output("empty_latency", last_pulse_cyc - nf_cyc, 0);
      check_output("empty_area", area_out, 0);
      check_output("empty_x", x_out, 104);
      check_output("empty_y", y_out, 202);
      idle(4);

      // Mask vector table
      for (int i = 0; i < 14; i++) begin
         win_lo = mask_table[i].lo;
         win_up = mask_table[i].up;
         apply_stimulus(mask_table[i].valid, int'($urandom_range(0, 1279)),
                        int'($urandom_range(0, 719)), mask_table[i].cr, 1'b0);
         check_output($sformatf("mask_vec%0d", i), mask_out, mask_table[i].exp_mask);
      end
      win_lo = 100;
      win_up = 200;
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(40);

      // Boundary pixel on the new_frame cycle belongs to the new frame
      apply_stimulus(1'b1, 20, 30, 150, 1'b0);
      apply_stimulus(1'b1, 40, 50, 150, 1'b0);
      apply_stimulus(1'b1, 5, 7, 150, 1'b1);
      idle(40);
      check_output("boundary_old_x", x_out, 30);
      check_output("boundary_old_y", y_out, 40);
      check_output("boundary_old_area", area_out, 2);
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(40);
      check_output("boundary_new_x", x_out, 5);
      check_output("boundary_new_y", y_out, 7);
      check_output("boundary_new_area", area_out, 1);

      // new_frame during DIVIDE is ignored, and its frame's pixels are dropped
      apply_stimulus(1'b1, 300, 100, 150, 1'b0);
      apply_stimulus(1'b1, 302, 104, 150, 1'b0);
      p0 = pulse_count;
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      apply_stimulus(1'b1, 50, 60, 150, 1'b0);
      idle(8);
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(40);
      check_output("overlap_pulses", pulse_count - p0, 1);
      check_output("overlap_x", x_out, 301);
      check_output("overlap_y", y_out, 102);
      check_output("overlap_area", area_out, 2);
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      check_output("overlap_after_area", area_out, 0);
      idle(4);

      // Random frames against the model, some too short to finish dividing
      for (int f = 0; f < 10; f++) begin
         win_lo = int'($urandom_range(40, 160));
         win_up = (f == 5) ? win_lo - 10 : win_lo + int'($urandom_range(0, 90));
         len    = int'($urandom_range(5, 70));
         for (int p = 0; p < len; p++) begin
            apply_stimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 1279)),
                           int'($urandom_range(0, 719)), int'($urandom_range(0, 255)), 1'b0);
         end
         apply_stimulus($urandom_range(0, 1) != 0, int'($urandom_range(0, 1279)),
                        int'($urandom_range(0, 719)), int'($urandom_range(0, 255)), 1'b1);
      end
      idle(40);

      // Reset asserted in the middle of a division
      win_lo = 100;
      win_up = 200;
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(40);
      apply_stimulus(1'b1, 1000, 700, 150, 1'b0);
      apply_stimulus(1'b1, 1002, 702, 150, 1'b0);
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(40);
      check_output("prereset_x", x_out, 1001);
      apply_stimulus(1'b1, 10, 20, 150, 1'b0);
      apply_stimulus(1'b0, 0, 0, 0, 1'b1);
      idle(12);
      p0 = pulse_count;
      #2;
      sys_rst_pixel_n = 1'b0;
      #1;
      check_output("rst_async_busy", busy_out, 0);
      check_output("rst_async_x", x_out, 0);
      check_output("rst_async_y", y_out, 0);
      check_output("rst_async_area", area_out, 0);
      check_output("rst_async_valid", centroid_valid_out, 0);
      model_reset();
      repeat (2) @(posedge clk_pixel);
      #1;
      sys_rst_pixel_n = 1'b1;
      idle(40);
      check_output("rst_no_pulse", pulse_count - p0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
